ps2_host_tx: RTL and testbench

PS/2 host-to-device transmitter. It sends one command byte to the keyboard, such as 0xED (set LEDs) or 0xF4 (enable). It is the outbound counterpart of the keyboard scan-code input path. It drives the open-drain PS/2 clock and data lines through active-high pull-low enables, and reports completion or failure to the controlling logic. While busy is high, the controller must ignore incoming scan-code bytes.

---
 rtl/ps2_host_tx.sv | 193 +++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, issues a request-to-send,
// shifts out one command byte with odd parity on device clocks, and checks the ACK.
module ps2_host_tx #(
    parameter int unsigned INHIBIT_CYCLES = 5000,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic [7:0] cmd_data,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe,
    output logic       busy,
    output logic       done,
    output logic       error
);

    localparam int unsigned INH_W = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
    localparam int unsigned TO_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TO_W-1:0]  TO_MAX   = TO_W'(TIMEOUT_CYCLES);

    typedef enum logic [3:0] {
        IDLE,
        INHIBIT,
        REQ,
        DATA,
        PARITY,
        STOP,
        WAIT_IDLE,
        DONE,
        ERR
    } state_t;

    state_t           state, state_next;
    logic [1:0]       clk_sync, dat_sync;
    logic             clk_prev;
    logic             clk_s, dat_s, fe;
    logic [7:0]       cmd_byte;
    logic             parity;
    logic [3:0]       bit_idx;
    logic             dat_q;
    logic [INH_W-1:0] inh_cnt;
    logic [TO_W-1:0]  to_cnt;
    logic             timeout, counting;
    logic             load_cmd, shift_en, par_en, rel_en;

    // Synchronisers idle high so reset never fabricates a falling edge.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            clk_sync <= '1;
            dat_sync <= '1;
            clk_prev <= 1'b1;
        end else begin
            clk_sync <= {clk_sync[0], ps2_clk_in};
            dat_sync <= {dat_sync[0], ps2_dat_in};
            clk_prev <= clk_sync[1];
        end
    end

    assign clk_s    = clk_sync[1];
    assign dat_s    = dat_sync[1];
    assign fe       = clk_prev & ~clk_s;
    assign counting = (state == REQ) || (state == DATA) || (state == PARITY) ||
                      (state == STOP) || (state == WAIT_IDLE);
    assign timeout  = (to_cnt >= TO_LAST);

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        load_cmd   = 1'b0;
        shift_en   = 1'b0;
        par_en     = 1'b0;
        rel_en     = 1'b0;
        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    load_cmd   = 1'b1;
                    state_next = INHIBIT;
                end
            end
            INHIBIT: begin
                if (inh_cnt == INH_LAST) state_next = REQ;
            end
            REQ: begin
                if (timeout) begin
                    state_next = ERR;
                end else if (fe) begin
                    shift_en   = 1'b1;
                    state_next = DATA;
                end
            end
            DATA: begin
                // bit_idx counts bits already placed; 8 means the parity edge.
                if (timeout) begin
                    state_next = ERR;
                end else if (fe) begin
                    if (bit_idx == 4'd8) begin
                        par_en     = 1'b1;
                        state_next = PARITY;
                    end else begin
                        shift_en = 1'b1;
                    end
                end
            end
            PARITY: begin
                if (timeout) begin
                    state_next = ERR;
                end else if (fe) begin
                    rel_en     = 1'b1;
                    state_next = STOP;
                end
            end
            STOP: begin
                if (timeout) begin
                    state_next = ERR;
                end else if (fe) begin
                    state_next = dat_s ? ERR : WAIT_IDLE;
                end
            end
            WAIT_IDLE: begin
                if (timeout) begin
                    state_next = ERR;
                end else if (clk_s && dat_s) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            ERR:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        cmd_ready  = (state == IDLE);
        busy       = (state != IDLE);
        done       = (state == DONE);
        error      = (state == ERR);
        ps2_clk_oe = (state == INHIBIT);
        ps2_dat_oe = ((state == INHIBIT) && (inh_cnt == INH_LAST)) ||
                     (state == REQ) ||
                     (((state == DATA) || (state == PARITY) || (state == STOP)) && dat_q);
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            cmd_byte <= '0;
            parity   <= 1'b0;
            bit_idx  <= '0;
            dat_q    <= 1'b0;
            inh_cnt  <= '0;
            to_cnt   <= '0;
        end else begin
            if (load_cmd) begin
                cmd_byte <= cmd_data;
                parity   <= ~^cmd_data;
                bit_idx  <= '0;
                dat_q    <= 1'b0;
            end else if (shift_en) begin
                dat_q   <= ~cmd_byte[bit_idx[2:0]];
                bit_idx <= bit_idx + 4'd1;
            end else if (par_en) begin
                dat_q <= ~parity;
            end else if (rel_en) begin
                dat_q <= 1'b0;
            end

            if ((state == INHIBIT) && (inh_cnt != INH_LAST)) begin
                inh_cnt <= inh_cnt + 1'b1;
            end else begin
                inh_cnt <= '0;
            end

            if (counting) begin
                if (to_cnt != TO_MAX) to_cnt <= to_cnt + 1'b1;
            end else begin
                to_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx: a PS/2 device model clocks the byte out,
// optionally ACKs, and the sampled frame and status pulses are checked.
module tb_ps2_host_tx;

    localparam int unsigned INH = 5000;
    localparam int unsigned TO  = 3000;
    localparam int unsigned H   = 40;

    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic [7:0] cmd_data = '0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready, ps2_clk_oe, ps2_dat_oe, busy, done, error;
    logic       ps2_clk_in, ps2_dat_in;
    logic       dev_clk = 1'b1;
    logic       dev_dat = 1'b1;

    // Open-drain lines: either side can pull low.
    assign ps2_clk_in = dev_clk & ~ps2_clk_oe;
    assign ps2_dat_in = dev_dat & ~ps2_dat_oe;

    ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
        .clock      (clock),
        .resetn     (resetn),
        .cmd_data   (cmd_data),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .ps2_clk_in (ps2_clk_in),
        .ps2_dat_in (ps2_dat_in),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_dat_oe (ps2_dat_oe),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    always #10 clock = ~clock;

    int unsigned cyc = 0;
    int errors = 0;
    int checks = 0;
    int done_cnt = 0, err_cnt = 0, both_cnt = 0;
    int inh_run = 0, inh_dat = 0, inh_last = 0, inh_dat_last = 0, inh_start_done = 0;

    always @(posedge clock) begin
        cyc      <= cyc + 1;
        done_cnt <= done_cnt + int'(done);
        err_cnt  <= err_cnt + int'(error);
        both_cnt <= both_cnt + int'(done & error);
    end

    always @(negedge clock) begin
        if (ps2_clk_oe) begin
            inh_run <= inh_run + 1;
            inh_dat <= inh_dat + int'(ps2_dat_oe);
            if (inh_run == 0) inh_start_done <= done_cnt;
        end else if (inh_run != 0) begin
            inh_last     <= inh_run;
            inh_dat_last <= inh_dat;
            inh_run      <= 0;
            inh_dat      <= 0;
        end
    end

    initial begin
        repeat (150000) @(posedge clock);
        $display("FAIL watchdog: got cycle %0d required finish earlier", cyc);
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic [7:0] cmd;
        bit         ack;
        logic       par;
        int         exp_done;
        int         exp_err;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        int n = 0;
        @(negedge clock);
        while (!cmd_ready && n < 1000) begin
            @(negedge clock);
            n++;
        end
        chk("send_ready", 32'(cmd_ready), 1);
        cmd_data  = b;
        cmd_valid = 1'b1;
        @(negedge clock);
        cmd_valid = 1'b0;
    endtask

    // bits[7:0] data, bits[8] parity, bits[9] stop, as seen by the device.
    task automatic dev_run(input int n_edges, input bit ack, output logic [9:0] bits);
        int n;
        bits = '0;
        n = 0;
        while (!ps2_clk_oe && n < 100) begin
            @(negedge clock);
            n++;
        end
        chk("inhibit_start", 32'(ps2_clk_oe), 1);
        n = 0;
        while (ps2_clk_oe && n < int'(INH) + 100) begin
            @(negedge clock);
            n++;
        end
        chk("inhibit_end", 32'(ps2_clk_oe), 0);
        repeat (H) @(negedge clock);
        for (int e = 1; e <= n_edges; e++) begin
            dev_clk = 1'b0;
            repeat (H) @(negedge clock);
            if (e <= 10) bits[e-1] = ps2_dat_in;
            dev_clk = 1'b1;
            if (e == 10 && ack) dev_dat = 1'b0;
            if (e == 11) dev_dat = 1'b1;
            repeat (H) @(negedge clock);
        end
    endtask

    task automatic run_vec(input vec_t v);
        logic [9:0] bits;
        int d0, e0;
        d0 = done_cnt;
        e0 = err_cnt;
        send(v.cmd);
        dev_run(11, v.ack, bits);
        repeat (10) @(negedge clock);
        chk("data_byte", 32'(bits[7:0]), 32'(v.cmd));
        chk("parity_bit", 32'(bits[8]), 32'(v.par));
        chk("stop_bit", 32'(bits[9]), 1);
        chk("done_pulses", done_cnt - d0, v.exp_done);
        chk("error_pulses", err_cnt - e0, v.exp_err);
        chk("end_clk_oe", 32'(ps2_clk_oe), 0);
        chk("end_dat_oe", 32'(ps2_dat_oe), 0);
        chk("end_busy", 32'(busy), 0);
        chk("end_cmd_ready", 32'(cmd_ready), 1);
        chk("inhibit_len", inh_last, INH);
        chk("inhibit_start_bit_cycles", inh_dat_last, 1);
    endtask

    initial begin
        logic [9:0] bits;
        int d0, e0, n;
        int unsigned t0, t1;
        logic prev;

        vecs[0] = '{cmd: 8'hED, ack: 1'b1, par: 1'b1, exp_done: 1, exp_err: 0};
        vecs[1] = '{cmd: 8'h01, ack: 1'b1, par: 1'b0, exp_done: 1, exp_err: 0};
        vecs[2] = '{cmd: 8'hFF, ack: 1'b1, par: 1'b1, exp_done: 1, exp_err: 0};
        vecs[3] = '{cmd: 8'hF4, ack: 1'b1, par: 1'b0, exp_done: 1, exp_err: 0};
        vecs[4] = '{cmd: 8'h00, ack: 1'b0, par: 1'b1, exp_done: 0, exp_err: 1};

        repeat (3) @(negedge clock);
        chk("rst_cmd_ready", 32'(cmd_ready), 1);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_clk_oe", 32'(ps2_clk_oe), 0);
        chk("rst_dat_oe", 32'(ps2_dat_oe), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_error", 32'(error), 0);
        resetn = 1'b1;

        foreach (vecs[i]) run_vec(vecs[i]);

        // Back to back: second request held through the first transfer.
        d0 = done_cnt;
        e0 = err_cnt;
        @(negedge clock);
        cmd_data  = 8'h01;
        cmd_valid = 1'b1;
        @(negedge clock);
        cmd_data = 8'hFF;
        dev_run(11, 1'b1, bits);
        chk("b2b_first_byte", 32'(bits[7:0]), 32'h01);
        chk("b2b_first_parity", 32'(bits[8]), 0);
        chk("b2b_second_inhibiting", 32'(ps2_clk_oe), 1);
        chk("b2b_accept_after_done", inh_start_done, d0 + 1);
        cmd_valid = 1'b0;
        dev_run(11, 1'b1, bits);
        repeat (10) @(negedge clock);
        chk("b2b_second_byte", 32'(bits[7:0]), 32'hFF);
        chk("b2b_second_parity", 32'(bits[8]), 1);
        chk("b2b_done_pulses", done_cnt - d0, 2);
        chk("b2b_error_pulses", err_cnt - e0, 0);

        // Silent device: timeout measured from REQ entry.
        d0 = done_cnt;
        e0 = err_cnt;
        send(8'h55);
        n = 0;
        while (!ps2_clk_oe && n < 100) begin
            @(negedge clock);
            n++;
        end
        n = 0;
        while (ps2_clk_oe && n < int'(INH) + 100) begin
            @(negedge clock);
            n++;
        end
        t0 = cyc;
        chk("req_dat_oe", 32'(ps2_dat_oe), 1);
        prev = ps2_dat_oe;
        n = 0;
        while (!error && n < int'(TO) + 100) begin
            prev = ps2_dat_oe;
            @(negedge clock);
            n++;
        end
        t1 = cyc;
        chk("timeout_latency", t1 - t0, TO);
        chk("timeout_dat_release", 32'(ps2_dat_oe), 0);
        chk("timeout_dat_before", 32'(prev), 1);
        repeat (5) @(negedge clock);
        chk("timeout_error_pulses", err_cnt - e0, 1);
        chk("timeout_done_pulses", done_cnt - d0, 0);

        // Reset while bit 4 (a zero, so data is pulled low) is on the line.
        send(8'h6B);
        dev_run(5, 1'b0, bits);
        chk("pre_reset_bits", 32'(bits[3:0]), 32'hB);
        chk("pre_reset_dat_oe", 32'(ps2_dat_oe), 1);
        d0 = done_cnt;
        e0 = err_cnt;
        resetn = 1'b0;
        @(negedge clock);
        resetn = 1'b1;
        chk("mid_reset_clk_oe", 32'(ps2_clk_oe), 0);
        chk("mid_reset_dat_oe", 32'(ps2_dat_oe), 0);
        chk("mid_reset_cmd_ready", 32'(cmd_ready), 1);
        repeat (5) @(negedge clock);
        chk("mid_reset_done", done_cnt - d0, 0);
        chk("mid_reset_error", err_cnt - e0, 0);
        run_vec('{cmd: 8'hF4, ack: 1'b1, par: 1'b0, exp_done: 1, exp_err: 0});

        chk("done_error_overlap", both_cnt, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
